rom_read_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one single-port synchronous BRAM/ROM (MEMORY_V-class, 64x20, read-only).
- Accepts at most one read per cycle. Drives the memory address, tracks which requester owns each in-flight read through the memory pipeline, and returns registered data with a per-requester valid strobe.
- Sits between the memory instance and its consumers. It replaces direct address driving by testbenches and logic.

---
 rtl/rom_read_arbiter.sv | 105 ++++++++++
 tb/tb_rom_read_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Two-requester round-robin read arbiter in front of a single-port synchronous ROM.
// Issues at most one read per cycle and tracks which requester owns each read in
// flight, so the returned data can be tagged with a per-requester valid strobe.
module rom_read_arbiter #(
   parameter int unsigned AW  = 6,
   parameter int unsigned DW  = 20,
   parameter int unsigned LAT = 1
) (
   input  logic          clka,
   input  logic          rsta_n,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   output logic          gnt0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   output logic          gnt1,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_douta,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid0,
   output logic          rd_valid1,
   output logic          busy
);

   // One stage beyond the capture point, so busy still covers the return cycle.
   localparam int unsigned Stages = LAT + 1;
   localparam int unsigned CapIdx = LAT - 1;

   // rr_ptr_q names the requester that wins the next contention (reset: requester 0).
   logic              rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]     last_addr_q, last_addr_d;
   logic [Stages-1:0] own_vld_q, own_vld_d;
   logic [Stages-1:0] own_id_q, own_id_d;
   logic [DW-1:0]     rd_data_q, rd_data_d;
   logic              rd_valid0_q, rd_valid0_d;
   logic              rd_valid1_q, rd_valid1_d;
   logic              grant;
   logic              cap;

   // Combinational arbitration and memory address selection.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rsta_n) begin
         if (req0 && req1) begin
            gnt0 = ~rr_ptr_q;
            gnt1 = rr_ptr_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
      grant = gnt0 | gnt1;
      if (gnt1) begin
         mem_addr = addr1;
      end else if (gnt0) begin
         mem_addr = addr0;
      end else begin
         mem_addr = last_addr_q;
      end
   end

   // Next-state: pointer, held address, owner pipeline and data return.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      last_addr_d = last_addr_q;
      if (grant) begin
         rr_ptr_d    = ~gnt1;
         last_addr_d = mem_addr;
      end
      own_vld_d   = {own_vld_q[Stages-2:0], grant};
      own_id_d    = {own_id_q[Stages-2:0], gnt1};
      cap         = own_vld_q[CapIdx];
      rd_data_d   = cap ? mem_douta : rd_data_q;
      rd_valid0_d = cap & ~own_id_q[CapIdx];
      rd_valid1_d = cap & own_id_q[CapIdx];
   end

   // State registers, cleared asynchronously so in-flight reads are dropped.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         rr_ptr_q    <= 1'b0;
         last_addr_q <= '0;
         own_vld_q   <= '0;
         own_id_q    <= '0;
         rd_data_q   <= '0;
         rd_valid0_q <= 1'b0;
         rd_valid1_q <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         last_addr_q <= last_addr_d;
         own_vld_q   <= own_vld_d;
         own_id_q    <= own_id_d;
         rd_data_q   <= rd_data_d;
         rd_valid0_q <= rd_valid0_d;
         rd_valid1_q <= rd_valid1_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_valid0 = rd_valid0_q;
   assign rd_valid1 = rd_valid1_q;
   assign busy      = |own_vld_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: an LAT=1 and an LAT=3 instance share stimulus,
// each behind its own ROM model returning {14'd0, addr}.
module tb_rom_read_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [5:0]  addr0, addr1;

   logic        gnt0_a, gnt1_a, v0_a, v1_a, busy_a;
   logic [5:0]  maddr_a;
   logic [19:0] douta_a, data_a;

   logic        gnt0_b, gnt1_b, v0_b, v1_b, busy_b;
   logic [5:0]  maddr_b;
   logic [19:0] douta_b, data_b, m3a, m3b;

   int n_assert = 0;
   int n_fail   = 0;

   rom_read_arbiter #(.AW(6), .DW(20), .LAT(1)) dut_a (
      .clka(clk), .rsta_n(rst_n),
      .req0(req0), .addr0(addr0), .gnt0(gnt0_a),
      .req1(req1), .addr1(addr1), .gnt1(gnt1_a),
      .mem_addr(maddr_a), .mem_douta(douta_a),
      .rd_data(data_a), .rd_valid0(v0_a), .rd_valid1(v1_a), .busy(busy_a)
   );

   rom_read_arbiter #(.AW(6), .DW(20), .LAT(3)) dut_b (
      .clka(clk), .rsta_n(rst_n),
      .req0(req0), .addr0(addr0), .gnt0(gnt0_b),
      .req1(req1), .addr1(addr1), .gnt1(gnt1_b),
      .mem_addr(maddr_b), .mem_douta(douta_b),
      .rd_data(data_b), .rd_valid0(v0_b), .rd_valid1(v1_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM models: one-cycle and three-cycle read latency.
   always_ff @(posedge clk) begin
      douta_a <= {14'd0, maddr_a};
      m3a     <= {14'd0, maddr_b};
      m3b     <= m3a;
      douta_b <= m3b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1; addr0 = 6'd0; addr1 = 6'd0;
      repeat (2) @(posedge clk);
      // Reset state; grants forced low even with both requests up.
      @(negedge clk);
      chk("rst_gnt0", gnt0_a, 0);
      chk("rst_gnt1", gnt1_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_v0", v0_a, 0);
      chk("rst_v1", v1_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_maddr", maddr_a, 0);
      next_cyc();
      req0 = 1'b0; req1 = 1'b0;
      rst_n = 1'b1;
      next_cyc();

      // Single read from requester 0.
      req0 = 1'b1; addr0 = 6'd5;
      @(negedge clk);
      chk("s_gnt0", gnt0_a, 1);
      chk("s_gnt1", gnt1_a, 0);
      chk("s_maddr", maddr_a, 5);
      chk("s_busy0", busy_a, 0);
      next_cyc();
      req0 = 1'b0;
      @(negedge clk);
      chk("s_busy1", busy_a, 1);
      chk("s_v0_early", v0_a, 0);
      next_cyc();
      @(negedge clk);
      chk("s_v0", v0_a, 1);
      chk("s_v1", v1_a, 0);
      chk("s_data", data_a, 20'h00005);
      chk("s_busy2", busy_a, 1);
      next_cyc();
      @(negedge clk);
      chk("s_v0_after", v0_a, 0);
      chk("s_busy3", busy_a, 0);
      chk("s_data_hold", data_a, 20'h00005);

      // Contention after reset: grants and returns alternate 0,1,0,1.
      do_reset();
      addr0 = 6'd3; addr1 = 6'd9;
      for (int i = 0; i < 6; i++) begin
         req0 = (i < 4);
         req1 = (i < 4);
         @(negedge clk);
         chk($sformatf("c_gnt0_%0d", i), gnt0_a, (i < 4) && (i % 2 == 0));
         chk($sformatf("c_gnt1_%0d", i), gnt1_a, (i < 4) && (i % 2 == 1));
         chk($sformatf("c_v0_%0d", i), v0_a, (i >= 2) && (i % 2 == 0));
         chk($sformatf("c_v1_%0d", i), v1_a, (i >= 2) && (i % 2 == 1));
         if (i >= 2) chk($sformatf("c_data_%0d", i), data_a, (i % 2 == 0) ? 3 : 9);
         next_cyc();
      end
      repeat (4) next_cyc();

      // Idle hold: one grant to requester 1, then silence.
      req1 = 1'b1; addr1 = 6'd42;
      @(negedge clk);
      chk("i_gnt1", gnt1_a, 1);
      chk("i_maddr0", maddr_a, 42);
      next_cyc();
      req1 = 1'b0; addr1 = 6'd0; addr0 = 6'd11;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk($sformatf("i_maddr_%0d", i), maddr_a, 42);
         chk($sformatf("i_v1_%0d", i), v1_a, i == 2);
         chk($sformatf("i_v0_%0d", i), v0_a, 0);
         if (i == 2) chk("i_data", data_a, 20'h0002A);
         next_cyc();
      end
      chk("i_busy", busy_a, 0);

      // Reset mid-flight: read discarded; first contention goes to requester 0.
      req0 = 1'b1; addr0 = 6'd7;
      @(negedge clk);
      chk("r_gnt0", gnt0_a, 1);
      next_cyc();
      req0 = 1'b0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("r_v0_a", v0_a, 0);
      chk("r_data", data_a, 0);
      chk("r_busy", busy_a, 0);
      next_cyc();
      @(negedge clk);
      chk("r_v0_b", v0_a, 0);
      next_cyc();
      rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1; addr1 = 6'd9;
      @(negedge clk);
      chk("r_post_gnt0", gnt0_a, 1);
      chk("r_post_gnt1", gnt1_a, 0);
      next_cyc();
      req0 = 1'b0; req1 = 1'b0;

      // LAT=3 instance: addr 63 then back-to-back addr 0.
      do_reset();
      req1 = 1'b1; addr1 = 6'd63;
      @(negedge clk);
      chk("l_gnt1", gnt1_b, 1);
      chk("l_maddr", maddr_b, 63);
      next_cyc();
      req1 = 1'b0; req0 = 1'b1; addr0 = 6'd0;
      @(negedge clk);
      chk("l_gnt0", gnt0_b, 1);
      next_cyc();
      req0 = 1'b0;
      for (int i = 2; i <= 6; i++) begin
         @(negedge clk);
         chk($sformatf("l_v1_%0d", i), v1_b, i == 4);
         chk($sformatf("l_v0_%0d", i), v0_b, i == 5);
         if (i == 4) chk("l_data63", data_b, 20'h0003F);
         if (i == 5) chk("l_data0", data_b, 20'h00000);
         if (i == 4) chk("l_busy", busy_b, 1);
         next_cyc();
      end
      chk("l_busy_end", busy_b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
